node_mem_banked: RTL and testbench

NODE_MEM_BANKED -- requirements
Module: node_mem_banked

---
 rtl/node_mem_pkg.sv | 24 ++
 rtl/node_mem_bank.sv | 46 ++++
 rtl/node_mem_banked.sv | 168 ++++++++++++++++
 tb/tb_node_mem_banked.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/node_mem_pkg.sv
// node_mem_pkg: shared constants and helpers for the banked node memory.
//   RD_LAT          fixed handshake-to-response latency in cycles
//   DEF_*           default widths and counts for node_mem_banked
//   mem_op_e        request opcode (read / write)
//   port_idx_w()    bits needed to index NUM_PORTS ports (minimum 1)
package node_mem_pkg;

  localparam int RD_LAT        = 2;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 36;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_BANK_BITS = 1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  // Port counts are limited to 1..8, so three bits always suffice.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : ((n <= 4) ? 2 : 3);
  endfunction

endpackage

// File: rtl/node_mem_bank.sv
// node_mem_bank: one single-port synchronous RAM bank.
//   i_clk    rising-edge clock
//   i_en     access strobe for this cycle
//   i_we     1 = write i_wdata to i_row, 0 = read i_row
//   i_row    word row inside the bank
//   i_wdata  write data
//   o_rdata  registered read data, one cycle after the access
// With NODE_MEM_WRSP_EN defined a write also captures the old word
// (read-before-write); otherwise o_rdata only updates on reads.
// Contents are deliberately not reset so they survive rst_n.
module node_mem_bank #(
  parameter int ROW_W  = 9,
  parameter int DATA_W = 36
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ROW_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // RAM array access: synchronous read, old word returned on write when enabled.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
`ifdef NODE_MEM_WRSP_EN
      r_rdata <= r_mem[i_row];
`else
      if (!i_we) begin
        r_rdata <= r_mem[i_row];
      end
`endif
      if (i_we) begin
        r_mem[i_row] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/node_mem_banked.sv
// node_mem_banked: multi-port memory split into 2^BANK_BITS banks, one
// access per bank per cycle, round-robin arbitration per bank.
//   clk, rst_n        clock / asynchronous active-low reset
//   req_valid/ready   per-port handshake (ready combinational)
//   req_we            1 = write, 0 = read
//   req_addr/wdata    packed per-port address and write data
//   rsp_valid/rdata   per-port response, RD_LAT cycles after handshake
// Optional macro NODE_MEM_WRSP_EN: writes also respond with the word's
// previous contents.
// Pipeline: handshake at N -> request registered (stage 1) -> bank RAM
// access during N+1 -> bank output register + stage 2 valid at N+2.
module node_mem_banked
  import node_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int BANK_BITS = DEF_BANK_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_rdata
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  localparam int BK_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int PI_W      = port_idx_w(NUM_PORTS);
  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'((1 << BANK_BITS) - 1);

  // Per-port decoded fields
  logic [BK_W-1:0]   w_bank  [NUM_PORTS];
  logic [ROW_W-1:0]  w_row   [NUM_PORTS];
  logic [DATA_W-1:0] w_wdata [NUM_PORTS];

  // Arbitration results
  logic [NUM_BANKS-1:0] w_bank_gnt;
  logic [PI_W-1:0]      w_bank_port [NUM_BANKS];
  logic [NUM_PORTS-1:0] w_ready;

  // Pipeline state
  logic [PI_W-1:0]      r_ptr      [NUM_BANKS];
  logic [NUM_BANKS-1:0] r_s1_vld;
  mem_op_e              r_s1_op    [NUM_BANKS];
  logic [ROW_W-1:0]     r_s1_row   [NUM_BANKS];
  logic [DATA_W-1:0]    r_s1_wdata [NUM_BANKS];
  logic [PI_W-1:0]      r_s1_port  [NUM_BANKS];
  logic [NUM_BANKS-1:0] r_s2_vld;
  logic [PI_W-1:0]      r_s2_port  [NUM_BANKS];
  logic [DATA_W-1:0]    w_bank_rdata [NUM_BANKS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    logic [ADDR_W-1:0] w_addr;
    assign w_addr     = req_addr[p*ADDR_W +: ADDR_W];
    assign w_bank[p]  = BK_W'(w_addr & BANK_MASK);
    assign w_row[p]   = ROW_W'(w_addr >> BANK_BITS);
    assign w_wdata[p] = req_wdata[p*DATA_W +: DATA_W];
  end

  // Per-bank round-robin: scan ports starting at the bank pointer, first hit wins.
  always_comb begin
    int v_idx;
    w_ready    = '0;
    w_bank_gnt = '0;
    v_idx      = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_port[b] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        v_idx = int'(r_ptr[b]) + k;
        v_idx = (v_idx >= NUM_PORTS) ? (v_idx - NUM_PORTS) : v_idx;
        if (!w_bank_gnt[b] && req_valid[v_idx] && (int'(w_bank[v_idx]) == b)) begin
          w_bank_gnt[b]  = 1'b1;
          w_bank_port[b] = PI_W'(v_idx);
          w_ready[v_idx] = 1'b1;
        end else begin
          w_bank_gnt[b] = w_bank_gnt[b];
        end
      end
    end
  end

  // Grants are forced low while reset is asserted.
  assign req_ready = rst_n ? w_ready : '0;

  // Stage 1: capture the granted request per bank and advance its pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_ptr[b]      <= '0;
        r_s1_op[b]    <= OP_RD;
        r_s1_row[b]   <= '0;
        r_s1_wdata[b] <= '0;
        r_s1_port[b]  <= '0;
      end
    end else begin
      r_s1_vld <= w_bank_gnt;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_gnt[b]) begin
          r_ptr[b]      <= (w_bank_port[b] == PI_W'(NUM_PORTS - 1)) ? '0
                           : PI_W'(w_bank_port[b] + PI_W'(1));
          r_s1_op[b]    <= mem_op_e'(req_we[w_bank_port[b]]);
          r_s1_row[b]   <= w_row[w_bank_port[b]];
          r_s1_wdata[b] <= w_wdata[w_bank_port[b]];
          r_s1_port[b]  <= w_bank_port[b];
        end else begin
          r_ptr[b] <= r_ptr[b];
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    node_mem_bank #(
      .ROW_W  (ROW_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .i_clk   (clk),
      .i_en    (r_s1_vld[b]),
      .i_we    (r_s1_op[b] == OP_WR),
      .i_row   (r_s1_row[b]),
      .i_wdata (r_s1_wdata[b]),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // Stage 2: mark which bank outputs carry a response and for which port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_s2_port[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef NODE_MEM_WRSP_EN
        r_s2_vld[b] <= r_s1_vld[b];
`else
        r_s2_vld[b] <= r_s1_vld[b] && (r_s1_op[b] == OP_RD);
`endif
        r_s2_port[b] <= r_s1_port[b];
      end
    end
  end

  // Route bank outputs to ports; a port has at most one response per cycle.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_s2_vld[b]) begin
        rsp_valid[r_s2_port[b]] = 1'b1;
        rsp_rdata[int'(r_s2_port[b])*DATA_W +: DATA_W] = w_bank_rdata[b];
      end else begin
        rsp_valid = rsp_valid;
      end
    end
  end

endmodule

// File: tb/tb_node_mem_banked.sv
// Self-checking bench for node_mem_banked (2 ports, 2 banks, 36-bit data).
module tb_node_mem_banked;
  import node_mem_pkg::*;

  localparam int NP = 2;
  localparam int AW = 10;
  localparam int DW = 36;
  localparam int BB = 1;
  localparam int NB = 1 << BB;
`ifdef NODE_MEM_WRSP_EN
  localparam bit WRSP = 1'b1;
`else
  localparam bit WRSP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata, rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  node_mem_banked #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .BANK_BITS(BB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          c;
    logic [DW-1:0] d;
    bit          known;
  } rsp_t;

  rsp_t           eq [NP][$];
  logic [DW-1:0]  m_mem [int];
  int             m_ptr [NB];

  initial for (int b = 0; b < NB; b++) m_ptr[b] = 0;

  always @(negedge clk) begin
    logic [NP-1:0] e_rdy;
    rsp_t r;
    int   p, gp, a;
    if (!rst_n) begin
      chk("rst_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      for (int q = 0; q < NP; q++) eq[q].delete();
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    end else begin
      // expected grants: each bank serves the first requester at or after its pointer
      e_rdy = '0;
      for (int b = 0; b < NB; b++) begin
        gp = -1;
        for (int k = 0; k < NP; k++) begin
          p = (m_ptr[b] + k) % NP;
          if (gp < 0 && req_valid[p] && (int'(req_addr[p*AW +: AW]) % NB) == b) gp = p;
        end
        if (gp >= 0) begin
          e_rdy[gp] = 1'b1;
          m_ptr[b]  = (gp + 1) % NP;
        end
      end
      chk("req_ready", req_ready, e_rdy);
      // expected responses due this cycle
      for (int q = 0; q < NP; q++) begin
        bit ev;
        ev = (eq[q].size() > 0) && (eq[q][0].c == cyc);
        chk($sformatf("rsp_valid[%0d]", q), rsp_valid[q], ev);
        if (ev) begin
          r = eq[q].pop_front();
          if (r.known) chk($sformatf("rsp_rdata[%0d]", q), rsp_rdata[q*DW +: DW], r.d);
        end
      end
      // accepted requests update memory and schedule responses
      for (int q = 0; q < NP; q++) begin
        if (e_rdy[q]) begin
          a       = int'(req_addr[q*AW +: AW]);
          r.c     = cyc + RD_LAT;
          r.known = m_mem.exists(a);
          r.d     = r.known ? m_mem[a] : '0;
          if (req_we[q]) begin
            if (WRSP) eq[q].push_back(r);
            m_mem[a] = req_wdata[q*DW +: DW];
          end else begin
            eq[q].push_back(r);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input bit v, input bit we, input int a, input logic [DW-1:0] d);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = AW'(a);
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NP-1:0] pend;
    logic [63:0]   rw;
    int            a;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // write 0x005 then read it back: response two cycles after the read
    set_req(0, 1'b1, 1'b1, 'h005, 36'h123456789);
    @(negedge clk); chk("t31_wr_ready", req_ready, 2'b01);
    tick(); set_req(0, 1'b1, 1'b0, 'h005, 36'h0);
    @(negedge clk); chk("t31_rd_ready", req_ready, 2'b01);
    tick(); idle();
    @(negedge clk); chk("t31_rsp_early", rsp_valid, WRSP ? 2'b01 : 2'b00);
    tick();
    @(negedge clk); chk("t31_rsp_valid", rsp_valid, 2'b01);
    chk("t31_rdata", rsp_rdata[DW-1:0], 36'h123456789);
    tick();

    // bank-0 conflict: p0 wins first, then held p1 beats a fresh p0 request
    set_req(0, 1'b1, 1'b0, 'h004, 36'h0);
    set_req(1, 1'b1, 1'b0, 'h010, 36'h0);
    @(negedge clk); chk("t32_first", req_ready, 2'b01);
    tick();
    @(negedge clk); chk("t32_second", req_ready, 2'b10);
    tick(); req_valid[1] = 1'b0;
    @(negedge clk); chk("t32_third", req_ready, 2'b01);
    tick(); idle(); tick(); tick();

    // different banks: both granted, both respond together
    set_req(0, 1'b1, 1'b0, 'h004, 36'h0);
    set_req(1, 1'b1, 1'b0, 'h007, 36'h0);
    @(negedge clk); chk("t33_ready", req_ready, 2'b11);
    tick(); idle(); tick();
    @(negedge clk); chk("t33_rsp", rsp_valid, 2'b11);
    tick();

    // write on p0 then immediate read on p1 sees the new word
    set_req(0, 1'b1, 1'b1, 'h00A, 36'hAAA);
    @(negedge clk); chk("t34_wr_ready", req_ready, 2'b01);
    tick(); idle(); set_req(1, 1'b1, 1'b0, 'h00A, 36'h0);
    @(negedge clk); chk("t34_rd_ready", req_ready, 2'b10);
    tick(); idle(); tick();
    @(negedge clk); chk("t34_rsp", rsp_valid, 2'b10);
    chk("t34_rdata", rsp_rdata[DW +: DW], 36'hAAA);
    tick();

    // reset with two reads in flight: nothing comes back, RAM survives
    set_req(0, 1'b1, 1'b0, 'h005, 36'h0);
    set_req(1, 1'b1, 1'b0, 'h004, 36'h0);
    @(negedge clk); chk("t35_ready", req_ready, 2'b11);
    tick(); idle(); rst_n = 1'b0;
    @(negedge clk); chk("t35_rst_a", rsp_valid, 2'b00);
    tick();
    @(negedge clk); chk("t35_rst_b", rsp_valid, 2'b00);
    tick(); rst_n = 1'b1;
    @(negedge clk); chk("t35_post", rsp_valid, 2'b00);
    tick(); set_req(0, 1'b1, 1'b0, 'h005, 36'h0);
    @(negedge clk); chk("t35_rd_ready", req_ready, 2'b01);
    tick(); idle(); tick();
    @(negedge clk); chk("t35_rsp", rsp_valid, 2'b01);
    chk("t35_rdata", rsp_rdata[DW-1:0], 36'h123456789);
    tick();

`ifdef NODE_MEM_WRSP_EN
    // write response carries the previous word
    set_req(0, 1'b1, 1'b1, 'h00A, 36'h555);
    @(negedge clk); chk("t36_wr1_ready", req_ready, 2'b01);
    tick(); set_req(0, 1'b1, 1'b1, 'h00A, 36'hAAA);
    @(negedge clk); chk("t36_wr2_ready", req_ready, 2'b01);
    tick(); idle(); tick();
    @(negedge clk); chk("t36_rsp", rsp_valid[0], 1'b1);
    chk("t36_rdata", rsp_rdata[DW-1:0], 36'h555);
    tick();
`endif

    // randomized traffic, waiting ports hold their request
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pend = req_valid & ~req_ready;
      tick();
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 99) < 65) begin
            rw = {$urandom, $urandom};
            a  = ($urandom_range(0, 9) == 0) ? (1008 + $urandom_range(0, 15)) : $urandom_range(0, 15);
            set_req(p, 1'b1, 1'($urandom_range(0, 1)), a, rw[DW-1:0]);
          end else begin
            req_valid[p] = 1'b0;
          end
        end
      end
    end
    idle();
    repeat (4) tick();
    @(negedge clk);
    chk("drain", eq[0].size() + eq[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
